// File: rtl/mem_port_arbiter.sv
// Shares one mem_system instance between the fetch port and the data port, one transaction at a time.
// Latency: issue the cycle after a request is seen in IDLE; done follows mem_done combinationally (1 cycle minimum).
// Backpressure: a pending port that is not completing sees stall; data priority is capped by a starvation counter.
module mem_port_arbiter #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_rd,
    input  logic [15:0] i_addr,
    output logic [15:0] i_data_out,
    output logic        i_done,
    output logic        i_stall,
    output logic        i_hit,
    input  logic        d_rd,
    input  logic        d_wr,
    input  logic [15:0] d_addr,
    input  logic [15:0] d_data_in,
    output logic [15:0] d_data_out,
    output logic        d_done,
    output logic        d_stall,
    output logic        d_hit,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_data_in,
    output logic        mem_rd,
    output logic        mem_wr,
    input  logic [15:0] mem_data_out,
    input  logic        mem_done,
    input  logic        mem_stall,
    input  logic        mem_hit,
    input  logic        mem_err,
    output logic        err
);
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

    localparam logic [2:0] STARVE_MAX = 3'(STARVE_LIMIT);
    localparam logic       GNT_I      = 1'b0;
    localparam logic       GNT_D      = 1'b1;

    state_t      state_q, state_d;
    logic        grant_q, grant_d;
    logic [15:0] addr_q, addr_d;
    logic [15:0] data_q, data_d;
    logic        wr_q, wr_d;
    logic [2:0]  starve_cnt_q, starve_cnt_d;

    logic busy;
    logic complete;
    logic d_conflict;
    logic i_pend;
    logic d_pend;
    logic start;
    logic pick_d;
    logic unused_mem_stall;

    // mem_system signals completion through mem_done alone; its stall output carries no extra information here.
    assign unused_mem_stall = mem_stall;

    assign busy       = (state_q != ST_IDLE);
    assign complete   = busy & mem_done;
    // A simultaneous read+write is malformed and is never granted; it only raises err.
    assign d_conflict = d_rd & d_wr;
    assign i_pend     = i_rd;
    assign d_pend     = (d_rd | d_wr) & ~d_conflict;
    assign start      = ~busy & (i_pend | d_pend);
    // Data wins contention until fetch has lost STARVE_LIMIT times; '>=' keeps fetch winning even if the count overshot.
    assign pick_d     = d_pend & (~i_pend | (starve_cnt_q < STARVE_MAX));

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: IDLE arbitrates, ISSUE strobes memory for one cycle, WAIT holds until mem_done.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:  if (start) state_d = ST_ISSUE;
            ST_ISSUE: state_d = mem_done ? ST_IDLE : ST_WAIT;
            ST_WAIT:  if (mem_done) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Output logic: memory strobes from captured registers, completion routed to the granted port only.
    always_comb begin
        mem_rd      = (state_q == ST_ISSUE) & ~wr_q;
        mem_wr      = (state_q == ST_ISSUE) & wr_q;
        mem_addr    = addr_q;
        mem_data_in = data_q;
        i_done      = complete & (grant_q == GNT_I);
        d_done      = complete & (grant_q == GNT_D);
        i_hit       = i_done & mem_hit;
        d_hit       = d_done & mem_hit;
        i_data_out  = i_done ? mem_data_out : 16'h0000;
        d_data_out  = d_done ? mem_data_out : 16'h0000;
        // Stall and the protocol error terms are forced low while reset is asserted; mem_err always passes.
        i_stall     = rst & i_rd & ~i_done;
        d_stall     = rst & (d_rd | d_wr) & ~d_done;
        err         = mem_err | (rst & ~busy & (d_conflict | mem_done));
    end

    // Capture the granted request and update the starvation count when a transaction finishes.
    always_comb begin
        grant_d      = grant_q;
        addr_d       = addr_q;
        data_d       = data_q;
        wr_d         = wr_q;
        starve_cnt_d = starve_cnt_q;
        if (start) begin
            if (pick_d) begin
                grant_d = GNT_D;
                addr_d  = d_addr;
                data_d  = d_data_in;
                wr_d    = d_wr;
            end else begin
                grant_d = GNT_I;
                addr_d  = i_addr;
                wr_d    = 1'b0;
            end
        end
        if (complete) begin
            if (grant_q == GNT_I) begin
                starve_cnt_d = 3'd0;
            end else if (i_rd && (starve_cnt_q != 3'd7)) begin
                starve_cnt_d = starve_cnt_q + 3'd1;
            end
        end
    end

    // Datapath registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            grant_q      <= GNT_I;
            addr_q       <= 16'h0000;
            data_q       <= 16'h0000;
            wr_q         <= 1'b0;
            starve_cnt_q <= 3'd0;
        end else begin
            grant_q      <= grant_d;
            addr_q       <= addr_d;
            data_q       <= data_d;
            wr_q         <= wr_d;
            starve_cnt_q <= starve_cnt_d;
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus a randomized run against a transaction model.
// Inputs change on the falling edge; outputs are sampled 1ns later, away from the rising edge.
// The memory side is a simple stand-in that answers each strobe after a random 0..4 cycle latency.
module tb_mem_port_arbiter;
    localparam int LIMIT = 4;

    logic        clk;
    logic        rst;
    logic        i_rd;
    logic [15:0] i_addr;
    logic [15:0] i_data_out;
    logic        i_done, i_stall, i_hit;
    logic        d_rd, d_wr;
    logic [15:0] d_addr, d_data_in, d_data_out;
    logic        d_done, d_stall, d_hit;
    logic [15:0] mem_addr, mem_data_in;
    logic        mem_rd, mem_wr;
    logic [15:0] mem_data_out;
    logic        mem_done, mem_stall, mem_hit, mem_err;
    logic        err;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        bit          act;
        bit          first;
        bit          port;   // 0 = fetch, 1 = data
        logic [15:0] addr;
        logic [15:0] data;
        bit          wr;
    } txn_t;

    mem_port_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
        .clk(clk), .rst(rst),
        .i_rd(i_rd), .i_addr(i_addr), .i_data_out(i_data_out),
        .i_done(i_done), .i_stall(i_stall), .i_hit(i_hit),
        .d_rd(d_rd), .d_wr(d_wr), .d_addr(d_addr), .d_data_in(d_data_in),
        .d_data_out(d_data_out), .d_done(d_done), .d_stall(d_stall), .d_hit(d_hit),
        .mem_addr(mem_addr), .mem_data_in(mem_data_in), .mem_rd(mem_rd), .mem_wr(mem_wr),
        .mem_data_out(mem_data_out), .mem_done(mem_done), .mem_stall(mem_stall),
        .mem_hit(mem_hit), .mem_err(mem_err), .err(err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic clear_inputs();
        i_rd = 1'b0; i_addr = 16'h0; d_rd = 1'b0; d_wr = 1'b0; d_addr = 16'h0; d_data_in = 16'h0;
        mem_data_out = 16'h0; mem_done = 1'b0; mem_stall = 1'b0; mem_hit = 1'b0; mem_err = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        clear_inputs();
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b0;
        i_rd = 1'b1; i_addr = 16'h1111; d_rd = 1'b1; d_wr = 1'b1; d_addr = 16'h2222;
        mem_done = 1'b1; mem_hit = 1'b1; mem_data_out = 16'hFFFF; mem_err = 1'b0;
        #1;
        checks++;
        if ({i_data_out, i_done, i_stall, i_hit, d_data_out, d_done, d_stall, d_hit,
             mem_addr, mem_data_in, mem_rd, mem_wr, err} !== 74'h0) begin
            failures++;
            $display("FAIL reset_outputs: i_stall=%b d_stall=%b mem_rd=%b mem_wr=%b err=%b mem_addr=%h (want all 0)",
                     i_stall, d_stall, mem_rd, mem_wr, err, mem_addr);
        end
        mem_err = 1'b1;
        #1;
        checks++;
        if (err !== 1'b1) begin
            failures++;
            $display("FAIL reset_err_follows_mem_err: err=%b want 1", err);
        end
        clear_inputs();
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_fetch_hit();
        do_reset();
        i_rd = 1'b1; i_addr = 16'h0040;
        #1;
        checks++;
        if (i_stall !== 1'b1 || mem_rd !== 1'b0 || i_done !== 1'b0) begin
            failures++;
            $display("FAIL fetch_idle: i_stall=%b mem_rd=%b i_done=%b want 1 0 0", i_stall, mem_rd, i_done);
        end
        @(negedge clk);
        mem_done = 1'b1; mem_hit = 1'b1; mem_data_out = 16'hC0DE;
        #1;
        checks++;
        if (mem_rd !== 1'b1 || mem_wr !== 1'b0 || mem_addr !== 16'h0040) begin
            failures++;
            $display("FAIL fetch_issue: mem_rd=%b mem_wr=%b mem_addr=%h want 1 0 0040", mem_rd, mem_wr, mem_addr);
        end
        checks++;
        if (i_done !== 1'b1 || i_hit !== 1'b1 || i_data_out !== 16'hC0DE || i_stall !== 1'b0 || d_done !== 1'b0) begin
            failures++;
            $display("FAIL fetch_complete: i_done=%b i_hit=%b i_data_out=%h i_stall=%b d_done=%b want 1 1 c0de 0 0",
                     i_done, i_hit, i_data_out, i_stall, d_done);
        end
        @(negedge clk);
        i_rd = 1'b0; mem_done = 1'b0; mem_hit = 1'b0;
        #1;
        checks++;
        if (mem_rd !== 1'b0 || i_done !== 1'b0 || i_stall !== 1'b0) begin
            failures++;
            $display("FAIL fetch_back_idle: mem_rd=%b i_done=%b i_stall=%b want 0 0 0", mem_rd, i_done, i_stall);
        end
    endtask

    task automatic test_data_write_miss();
        do_reset();
        d_wr = 1'b1; d_addr = 16'h1234; d_data_in = 16'hBEEF;
        #1;
        checks++;
        if (d_stall !== 1'b1 || mem_wr !== 1'b0) begin
            failures++;
            $display("FAIL dwr_idle: d_stall=%b mem_wr=%b want 1 0", d_stall, mem_wr);
        end
        @(negedge clk);
        #1;
        checks++;
        if (mem_wr !== 1'b1 || mem_rd !== 1'b0 || mem_addr !== 16'h1234 || mem_data_in !== 16'hBEEF ||
            d_stall !== 1'b1 || d_done !== 1'b0) begin
            failures++;
            $display("FAIL dwr_issue: mem_wr=%b mem_rd=%b addr=%h data=%h d_stall=%b d_done=%b want 1 0 1234 beef 1 0",
                     mem_wr, mem_rd, mem_addr, mem_data_in, d_stall, d_done);
        end
        for (int k = 1; k < 20; k++) begin
            @(negedge clk);
            #1;
            checks++;
            if (mem_wr !== 1'b0 || mem_rd !== 1'b0 || mem_addr !== 16'h1234 || mem_data_in !== 16'hBEEF ||
                d_stall !== 1'b1 || d_done !== 1'b0) begin
                failures++;
                $display("FAIL dwr_wait cycle %0d: mem_wr=%b addr=%h data=%h d_stall=%b d_done=%b want 0 1234 beef 1 0",
                         k, mem_wr, mem_addr, mem_data_in, d_stall, d_done);
            end
        end
        @(negedge clk);
        mem_done = 1'b1; mem_hit = 1'b0; mem_data_out = 16'h7777;
        #1;
        checks++;
        if (d_done !== 1'b1 || d_hit !== 1'b0 || d_stall !== 1'b0 || i_done !== 1'b0 ||
            mem_addr !== 16'h1234 || mem_data_in !== 16'hBEEF) begin
            failures++;
            $display("FAIL dwr_complete: d_done=%b d_hit=%b d_stall=%b i_done=%b addr=%h want 1 0 0 0 1234",
                     d_done, d_hit, d_stall, i_done, mem_addr);
        end
        @(negedge clk);
        clear_inputs();
    endtask

    task automatic test_starvation();
        int  cnt_m;
        int  grants;
        int  cycles;
        bit  exp_d;
        do_reset();
        cnt_m = 0; grants = 0; cycles = 0;
        i_rd = 1'b1; i_addr = 16'h0100; d_rd = 1'b1; d_addr = 16'h0200;
        while (grants < 10 && cycles < 60) begin
            @(negedge clk);
            cycles++;
            mem_done = mem_rd | mem_wr;
            mem_hit = mem_done;
            mem_data_out = 16'($urandom);
            #1;
            if (mem_done) begin
                exp_d = (cnt_m < LIMIT);
                checks++;
                if (d_done !== exp_d || i_done !== (exp_d ? 1'b0 : 1'b1) ||
                    i_stall !== exp_d || d_stall !== (exp_d ? 1'b0 : 1'b1)) begin
                    failures++;
                    $display("FAIL starve_grant %0d: d_done=%b i_done=%b i_stall=%b d_stall=%b want d_done=%b",
                             grants, d_done, i_done, i_stall, d_stall, exp_d);
                end
                checks++;
                if (mem_addr !== (exp_d ? 16'h0200 : 16'h0100)) begin
                    failures++;
                    $display("FAIL starve_addr %0d: mem_addr=%h want %h", grants, mem_addr,
                             exp_d ? 16'h0200 : 16'h0100);
                end
                if (exp_d) cnt_m++;
                else cnt_m = 0;
                grants++;
            end
        end
        checks++;
        if (grants != 10) begin
            failures++;
            $display("FAIL starve_timeout: grants=%0d want 10 within 60 cycles", grants);
        end
        @(negedge clk);
        clear_inputs();
    endtask

    task automatic test_reset_mid_wait();
        do_reset();
        i_rd = 1'b1; i_addr = 16'h0300;
        @(negedge clk);
        #1;
        checks++;
        if (mem_rd !== 1'b1 || mem_addr !== 16'h0300) begin
            failures++;
            $display("FAIL rstwait_issue: mem_rd=%b addr=%h want 1 0300", mem_rd, mem_addr);
        end
        @(negedge clk);
        #1;
        checks++;
        if (i_stall !== 1'b1 || mem_rd !== 1'b0 || mem_addr !== 16'h0300) begin
            failures++;
            $display("FAIL rstwait_wait: i_stall=%b mem_rd=%b addr=%h want 1 0 0300", i_stall, mem_rd, mem_addr);
        end
        #2;
        rst = 1'b0; mem_done = 1'b1; mem_hit = 1'b1; mem_data_out = 16'h9999;
        #1;
        checks++;
        if ({i_data_out, i_done, i_stall, i_hit, d_data_out, d_done, d_stall, d_hit,
             mem_addr, mem_data_in, mem_rd, mem_wr, err} !== 74'h0) begin
            failures++;
            $display("FAIL rstwait_async: i_done=%b i_stall=%b mem_addr=%h err=%b (want all 0)",
                     i_done, i_stall, mem_addr, err);
        end
        @(negedge clk);
        rst = 1'b1; mem_done = 1'b0; mem_hit = 1'b0;
        #1;
        checks++;
        if (i_stall !== 1'b1 || mem_rd !== 1'b0 || i_done !== 1'b0) begin
            failures++;
            $display("FAIL rstwait_release: i_stall=%b mem_rd=%b i_done=%b want 1 0 0", i_stall, mem_rd, i_done);
        end
        @(negedge clk);
        mem_done = 1'b1; mem_hit = 1'b1; mem_data_out = 16'h4242;
        #1;
        checks++;
        if (mem_rd !== 1'b1 || mem_addr !== 16'h0300 || i_done !== 1'b1 || i_data_out !== 16'h4242) begin
            failures++;
            $display("FAIL rstwait_fresh: mem_rd=%b addr=%h i_done=%b data=%h want 1 0300 1 4242",
                     mem_rd, mem_addr, i_done, i_data_out);
        end
        @(negedge clk);
        clear_inputs();
    endtask

    task automatic test_errors();
        do_reset();
        d_rd = 1'b1; d_wr = 1'b1; d_addr = 16'h0500;
        #1;
        checks++;
        if (err !== 1'b1 || mem_rd !== 1'b0 || mem_wr !== 1'b0) begin
            failures++;
            $display("FAIL err_conflict: err=%b mem_rd=%b mem_wr=%b want 1 0 0", err, mem_rd, mem_wr);
        end
        @(negedge clk);
        #1;
        checks++;
        if (err !== 1'b1 || mem_rd !== 1'b0 || mem_wr !== 1'b0) begin
            failures++;
            $display("FAIL err_conflict_nogrant: err=%b mem_rd=%b mem_wr=%b want 1 0 0", err, mem_rd, mem_wr);
        end
        // A conflicting data request does not block a fetch, and err is only flagged while idle.
        i_rd = 1'b1; i_addr = 16'h0600;
        @(negedge clk);
        mem_done = 1'b1; mem_hit = 1'b0; mem_data_out = 16'h0606;
        #1;
        checks++;
        if (mem_rd !== 1'b1 || mem_addr !== 16'h0600 || i_done !== 1'b1 || err !== 1'b0) begin
            failures++;
            $display("FAIL err_conflict_fetch: mem_rd=%b addr=%h i_done=%b err=%b want 1 0600 1 0",
                     mem_rd, mem_addr, i_done, err);
        end
        @(negedge clk);
        clear_inputs();
        #1;
        checks++;
        if (err !== 1'b0) begin
            failures++;
            $display("FAIL err_quiet: err=%b want 0", err);
        end
        mem_done = 1'b1;
        #1;
        checks++;
        if (err !== 1'b1 || i_done !== 1'b0 || d_done !== 1'b0) begin
            failures++;
            $display("FAIL err_done_idle: err=%b i_done=%b d_done=%b want 1 0 0", err, i_done, d_done);
        end
        mem_done = 1'b0; mem_err = 1'b1;
        #1;
        checks++;
        if (err !== 1'b1) begin
            failures++;
            $display("FAIL err_mem_err: err=%b want 1", err);
        end
        mem_err = 1'b0;
    endtask

    task automatic test_random();
        txn_t t;
        int   starve;
        bit   mpend;
        int   mleft;
        bit   i_fin, d_fin;
        bit   e_mrd, e_mwr, e_idone, e_ddone, e_err, i_want, d_want, pick_d;
        do_reset();
        t = '{default: 0};
        starve = 0; mpend = 0; mleft = 0; i_fin = 0; d_fin = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            // Requesters: drop after done, then raise a new request at random.
            if (i_fin) begin i_rd = 1'b0; i_fin = 0; end
            if (d_fin) begin d_rd = 1'b0; d_wr = 1'b0; d_fin = 0; end
            if (!i_rd && $urandom_range(0, 1) == 0) begin
                i_rd = 1'b1; i_addr = 16'($urandom);
            end
            if (!d_rd && !d_wr && $urandom_range(0, 1) == 0) begin
                if ($urandom_range(0, 1) == 1) d_wr = 1'b1;
                else d_rd = 1'b1;
                d_addr = 16'($urandom); d_data_in = 16'($urandom);
            end
            // Memory stand-in.
            mem_done = 1'b0; mem_hit = 1'b0; mem_data_out = 16'($urandom);
            mem_err = ($urandom_range(0, 15) == 0);
            if (!mpend && (mem_rd || mem_wr)) begin
                mpend = 1; mleft = int'($urandom_range(0, 4));
            end
            if (mpend) begin
                if (mleft == 0) begin
                    mem_done = 1'b1; mem_hit = 1'($urandom_range(0, 1)); mpend = 0;
                end else begin
                    mleft--;
                end
            end
            #1;
            e_mrd   = t.act && t.first && !t.wr;
            e_mwr   = t.act && t.first && t.wr;
            e_idone = t.act && !t.port && (mem_done === 1'b1);
            e_ddone = t.act && t.port && (mem_done === 1'b1);
            e_err   = (mem_err === 1'b1) || (!t.act && ((d_rd && d_wr) || (mem_done === 1'b1)));
            checks++;
            if (mem_rd !== e_mrd || mem_wr !== e_mwr) begin
                failures++;
                $display("FAIL rnd_strobe cyc %0d: mem_rd=%b mem_wr=%b want %b %b", cyc, mem_rd, mem_wr, e_mrd, e_mwr);
            end
            if (t.act) begin
                checks++;
                if (mem_addr !== t.addr || (t.wr && mem_data_in !== t.data)) begin
                    failures++;
                    $display("FAIL rnd_addr cyc %0d: mem_addr=%h mem_data_in=%h want %h %h",
                             cyc, mem_addr, mem_data_in, t.addr, t.data);
                end
            end
            checks++;
            if (i_done !== e_idone || d_done !== e_ddone) begin
                failures++;
                $display("FAIL rnd_done cyc %0d: i_done=%b d_done=%b want %b %b", cyc, i_done, d_done, e_idone, e_ddone);
            end
            checks++;
            if (i_hit !== (e_idone & mem_hit) || d_hit !== (e_ddone & mem_hit)) begin
                failures++;
                $display("FAIL rnd_hit cyc %0d: i_hit=%b d_hit=%b mem_hit=%b", cyc, i_hit, d_hit, mem_hit);
            end
            if (e_idone) begin
                checks++;
                if (i_data_out !== mem_data_out) begin
                    failures++;
                    $display("FAIL rnd_idata cyc %0d: i_data_out=%h want %h", cyc, i_data_out, mem_data_out);
                end
            end
            if (e_ddone) begin
                checks++;
                if (d_data_out !== mem_data_out) begin
                    failures++;
                    $display("FAIL rnd_ddata cyc %0d: d_data_out=%h want %h", cyc, d_data_out, mem_data_out);
                end
            end
            checks++;
            if (i_stall !== (i_rd & !e_idone) || d_stall !== ((d_rd | d_wr) & !e_ddone)) begin
                failures++;
                $display("FAIL rnd_stall cyc %0d: i_stall=%b d_stall=%b", cyc, i_stall, d_stall);
            end
            checks++;
            if (err !== e_err) begin
                failures++;
                $display("FAIL rnd_err cyc %0d: err=%b want %b", cyc, err, e_err);
            end
            // Advance the transaction model to the next cycle.
            if (t.act) begin
                if (mem_done === 1'b1) begin
                    if (t.port) begin
                        if (i_rd === 1'b1 && starve < 7) starve++;
                        d_fin = 1;
                    end else begin
                        starve = 0;
                        i_fin = 1;
                    end
                    t.act = 0;
                end else begin
                    t.first = 0;
                end
            end else begin
                i_want = (i_rd === 1'b1);
                d_want = ((d_rd ^ d_wr) === 1'b1);
                if (i_want || d_want) begin
                    pick_d  = d_want && (!i_want || starve < LIMIT);
                    t.act   = 1;
                    t.first = 1;
                    t.port  = pick_d;
                    t.addr  = pick_d ? d_addr : i_addr;
                    t.data  = d_data_in;
                    t.wr    = pick_d && (d_wr === 1'b1);
                end
            end
        end
        @(negedge clk);
        clear_inputs();
    endtask

    initial begin
        rst = 1'b0;
        clear_inputs();
        test_reset();
        test_fetch_hit();
        test_data_write_miss();
        test_starvation();
        test_reset_mid_wait();
        test_errors();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Two-port arbiter that shares a single `mem_system` cache/memory instance between the instruction-fetch port and the data-memory port of the processor. It accepts one outstanding request per port, grants the memory to one port at a time, and sequences each transaction as a one-cycle issue followed by a wait for `Done`. Read data, completion and hit status are routed back to the granted port. Data-side priority is bounded by a starvation counter so fetch always makes progress.

## Interface

- `STARVE_LIMIT`, default 4: consecutive data grants allowed while a fetch is pending before fetch is forced; legal range 1–7.

- `clk` input 1: system clock, all state on rising edge.
- `rst` input 1: reset, asynchronous and active-low.
- `i_rd` input 1: fetch read request; held until `i_done`.
- `i_addr` input 16: fetch address; held with `i_rd`.
- `i_data_out` output 16: fetch read data; valid when `i_done`=1.
- `i_done` output 1: one-cycle fetch completion pulse.
- `i_stall` output 1: fetch request pending and not completing this cycle.
- `i_hit` output 1: `mem_hit` qualified by `i_done`.
- `d_rd`, `d_wr` input 1 each: data read/write request; held until `d_done`.
- `d_addr`, `d_data_in` input 16 each: data address and write data.
- `d_data_out` output 16: data read data; valid when `d_done`=1.
- `d_done`, `d_stall`, `d_hit` output 1 each: as for the fetch port.
- `mem_addr`, `mem_data_in` output 16 each: to `mem_system` `Addr`/`DataIn`.
- `mem_rd`, `mem_wr` output 1 each: to `mem_system` `Rd`/`Wr`.
- `mem_data_out` input 16, `mem_done`, `mem_stall`, `mem_hit`, `mem_err` input 1 each: from `mem_system`.
- `err` output 1: protocol or memory error.

## Operation

- States: IDLE, ISSUE, WAIT. Registers: `state`, `grant` (0=I, 1=D), `addr_q`, `data_q`, `wr_q`, `starve_cnt[2:0]`.
- IDLE: requests are evaluated combinationally.
  - None pending: stay in IDLE.
  - Only one port pending: grant that port.
  - Both pending: grant I if `starve_cnt == STARVE_LIMIT`, else grant D.
  - On grant, capture address, data (D only), op and `grant`; go to ISSUE.
- ISSUE: drive `mem_rd`=~`wr_q` and `mem_wr`=`wr_q` for exactly this cycle, from the captured registers.
  - If `mem_done`=1 in this cycle (hit completing in one cycle), complete here and go to IDLE.
  - Otherwise go to WAIT.
- WAIT: `mem_rd`=`mem_wr`=0, and `mem_addr`/`mem_data_in` are held from the registers. On `mem_done`, complete and go to IDLE.
- Completion: pulse `done` on the granted port combinationally with `mem_done`. That port's `data_out`=`mem_data_out` and `hit`=`mem_hit`. The other port's done/hit are 0.
- `starve_cnt` update at the end of each transaction:
  - +1 (saturating at 7) when D completes while `i_rd`=1.
  - Cleared when I completes.
  - Unchanged otherwise.
- `x_stall` = port request asserted AND NOT `x_done`.
- `err` is combinational OR of:
  - `mem_err`;
  - `d_rd & d_wr` in IDLE (that D request is not granted that cycle);
  - `mem_done` while in IDLE.
- A requester that drops its request mid-transaction violates protocol. The transaction still completes and `done` still pulses.
- Reset (`rst`=0, any time): state→IDLE, `grant`=0, all captured registers=0, `starve_cnt`=0. Every output is 0 during reset except `err`, which follows `mem_err`. An in-flight transaction is abandoned; `mem_system` shares the same reset.

## Timing

- A request seen in IDLE in cycle N issues in cycle N+1.
- Earliest `done` is in cycle N+1 (one-cycle hit). A miss completes in the `mem_done` cycle.
- Back-to-back: after completion in cycle M, IDLE in M+1 arbitrates. The next issue is at M+2, giving a minimum 2-cycle gap between issues.
- `mem_addr`, `mem_data_in`, `mem_rd` and `mem_wr` are stable from ISSUE through completion.
- Requests arriving during ISSUE/WAIT are held off (`stall`=1) until the next IDLE.

## Test plan

- **Single fetch, one-cycle hit.** `i_rd`=1, `i_addr`=0x0040, `mem_done`/`mem_hit` in the ISSUE cycle → `mem_rd` high 1 cycle with `mem_addr`=0x0040; `i_done`=`i_hit`=1 the same cycle; `i_data_out`=`mem_data_out`; state returns to IDLE.
- **Data write miss.** `d_wr`=1, `d_addr`=0x1234, `d_data_in`=0xBEEF, `mem_done` 20 cycles later → `mem_wr` high exactly 1 cycle; addr/data held for 20 cycles; `d_stall`=1 until the `d_done` cycle; `d_hit`=0.
- **Simultaneous requests, `STARVE_LIMIT`=4, D held continuously.** D wins 4 transactions while `i_stall`=1; the 5th grant goes to I; `starve_cnt` returns to 0.
- **Reset mid-WAIT.** Drop `rst` low while in WAIT → all outputs 0 immediately (asynchronous), no `done` pulse. After release, a fresh `i_rd` request issues normally.
- **Errors.** `d_rd`=`d_wr`=1 in IDLE → `err`=1 and no `mem_rd`/`mem_wr`. `mem_done` pulsed in IDLE → `err`=1. `mem_err`=1 → `err`=1 in the same cycle.
